// File: rtl/sram_frame_reader.sv
`default_nettype none
// ============================================================================
//  Module   : sram_frame_reader
//  Purpose  : Avalon-MM read master that fetches one RGB565 frame from the
//             SRAM controller (one 16-bit word per pixel) and streams it to
//             the LCD pixel sink through a small read-return FIFO. Reads are
//             issued against a credit so the FIFO can never overflow.
//  Revision : 1.0  initial release
// ============================================================================
module sram_frame_reader #(
    parameter int                ADDR_W       = 20,
    parameter int                DATA_W       = 16,
    parameter logic [ADDR_W-1:0] FRAME_BASE   = '0,
    parameter int                FRAME_PIXELS = 76800,
    parameter int                FIFO_DEPTH   = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic              busy,
    output logic              frame_done,
    output logic              err_unexp,
    output logic [ADDR_W-1:0] avm_address,
    output logic [1:0]        avm_byteenable,
    output logic              avm_read,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_readdatavalid,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              pix_last
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = PTR_W + 1;            // holds 0..FIFO_DEPTH
    localparam int SUM_W = PTR_W + 2;            // holds 0..2*FIFO_DEPTH+1
    localparam int CNT_W = $clog2(FRAME_PIXELS + 1);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_PIXELS - 1);
    localparam logic [SUM_W-1:0] DEPTH_S  = SUM_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t              state_q;
    logic                busy_q;
    logic                frame_done_q;
    logic                err_q;
    logic                avm_read_q;
    logic [ADDR_W-1:0]   avm_address_q;
    logic [CNT_W-1:0]    issue_cnt_q;
    logic [CNT_W-1:0]    out_cnt_q;
    logic [OCC_W-1:0]    outstanding_q;
    logic [OCC_W-1:0]    outstanding_d;
    logic [OCC_W-1:0]    fifo_cnt_q;
    logic [OCC_W-1:0]    fifo_cnt_d;
    logic [PTR_W-1:0]    wr_ptr_q;
    logic [PTR_W-1:0]    rd_ptr_q;
    logic [DATA_W-1:0]   fifo_mem_q [FIFO_DEPTH];

    logic                w_push;
    logic                w_pop;
    logic                w_unexp;
    logic [SUM_W-1:0]    w_credit_sum;
    logic                w_credit_ok;
    logic                w_last_issue;
    logic                w_last_pop;

    // Returned data is only accepted when a read is actually owed to us.
    assign w_push  = avm_readdatavalid & (outstanding_q != '0);
    assign w_unexp = avm_readdatavalid & (outstanding_q == '0);
    assign w_pop   = pix_valid & pix_ready;

    // The read currently on the bus is counted so the next-cycle decision
    // never over-commits FIFO space.
    assign w_credit_sum = SUM_W'(outstanding_q) + SUM_W'(fifo_cnt_q) + SUM_W'(avm_read_q);
    assign w_credit_ok  = (w_credit_sum < DEPTH_S);

    assign w_last_issue = avm_read_q & (issue_cnt_q == LAST_IDX);
    assign w_last_pop   = w_pop & pix_last;

    // Stream side is a direct view of the FIFO head.
    assign pix_valid = (fifo_cnt_q != '0);
    assign pix_data  = fifo_mem_q[rd_ptr_q];
    assign pix_last  = pix_valid & (out_cnt_q == LAST_IDX);

    assign busy           = busy_q;
    assign frame_done     = frame_done_q;
    assign err_unexp      = err_q;
    assign avm_read       = avm_read_q;
    assign avm_address    = avm_address_q;
    assign avm_byteenable = 2'b11;

    // Next value of the in-flight read count (issue increments, return decrements).
    always_comb begin
        outstanding_d = outstanding_q;
        if (avm_read_q && !w_push) begin
            outstanding_d = outstanding_q + OCC_W'(1);
        end else if (!avm_read_q && w_push) begin
            outstanding_d = outstanding_q - OCC_W'(1);
        end
    end

    // Next value of the FIFO occupancy (push and pop together cancel).
    always_comb begin
        fifo_cnt_d = fifo_cnt_q;
        if (w_push && !w_pop) begin
            fifo_cnt_d = fifo_cnt_q + OCC_W'(1);
        end else if (!w_push && w_pop) begin
            fifo_cnt_d = fifo_cnt_q - OCC_W'(1);
        end
    end

    // Frame sequencing, read issue and all registered status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            err_q         <= 1'b0;
            avm_read_q    <= 1'b0;
            avm_address_q <= FRAME_BASE;
            issue_cnt_q   <= '0;
            out_cnt_q     <= '0;
        end else begin
            frame_done_q <= 1'b0;
            if (w_unexp) begin
                err_q <= 1'b1;
            end
            // Every cycle with avm_read high is an accepted request.
            if (avm_read_q) begin
                avm_address_q <= avm_address_q + ADDR_W'(1);
                issue_cnt_q   <= issue_cnt_q + CNT_W'(1);
            end
            if (w_pop) begin
                out_cnt_q <= out_cnt_q + CNT_W'(1);
            end
            case (state_q)
                S_IDLE: begin
                    avm_read_q <= 1'b0;
                    if (start) begin
                        state_q       <= S_FETCH;
                        busy_q        <= 1'b1;
                        avm_address_q <= FRAME_BASE;
                        issue_cnt_q   <= '0;
                        out_cnt_q     <= '0;
                        // FIFO is empty and nothing is owed in IDLE, so the
                        // first read can go out without a credit check.
                        avm_read_q    <= 1'b1;
                    end
                end
                S_FETCH: begin
                    avm_read_q <= w_credit_ok & ~w_last_issue;
                    if (w_last_issue) begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    avm_read_q <= 1'b0;
                    // The final pixel is the last word requested, so once it
                    // is handshaken nothing is outstanding and the FIFO is empty.
                    if (w_last_pop && outstanding_q == '0) begin
                        state_q      <= S_IDLE;
                        busy_q       <= 1'b0;
                        frame_done_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    busy_q     <= 1'b0;
                    avm_read_q <= 1'b0;
                end
            endcase
        end
    end

    // Read-return FIFO bookkeeping: pointers, occupancy and outstanding reads.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            fifo_cnt_q    <= '0;
            outstanding_q <= '0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            fifo_cnt_q    <= fifo_cnt_d;
            outstanding_q <= outstanding_d;
        end
    end

    // FIFO storage; contents need no reset because occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (w_push) begin
            fifo_mem_q[wr_ptr_q] <= avm_readdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_frame_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sram_frame_reader
//  Purpose  : Self-checking bench for sram_frame_reader. Models the SRAM
//             controller (random in-order latency) and the LCD sink, and
//             compares the delivered stream against memory contents.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sram_frame_reader;

    localparam int          N     = 64;
    localparam int          DEPTH = 16;
    localparam logic [19:0] BASE  = 20'h00100;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        busy;
    logic        frame_done;
    logic        err_unexp;
    logic [19:0] avm_address;
    logic [1:0]  avm_byteenable;
    logic        avm_read;
    logic [15:0] avm_readdata;
    logic        avm_readdatavalid;
    logic [15:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic        pix_last;

    int asserts  = 0;
    int failures = 0;

    int cyc       = 0;
    int lat_min   = 1;
    int lat_max   = 1;
    int ready_pct = 100;
    bit inject_rdv = 1'b0;

    logic [19:0] pend_addr[$];
    int          pend_due[$];
    logic [19:0] rd_log[$];
    logic [15:0] cap_data[$];
    bit          cap_last[$];
    int          done_cnt    = 0;
    int          busy_bad    = 0;
    int          credit_viol = 0;

    bit          first_read;
    logic [19:0] first_addr;
    bit          first_busy;
    int          frame_cycles;
    int          stall_reads;
    int          stall_caps;
    bit          stall_read;
    bit          stall_valid;
    int          ctl_lat;
    int          ctl_due;

    // Memory contents seen by the controller model.
    function automatic logic [15:0] mem_f(input logic [19:0] a);
        return (a[15:0] * 16'h9E37) ^ {a[19:16], 12'h5A5};
    endfunction

    sram_frame_reader #(
        .ADDR_W       (20),
        .DATA_W       (16),
        .FRAME_BASE   (BASE),
        .FRAME_PIXELS (N),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .start             (start),
        .busy              (busy),
        .frame_done        (frame_done),
        .err_unexp         (err_unexp),
        .avm_address       (avm_address),
        .avm_byteenable    (avm_byteenable),
        .avm_read          (avm_read),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid),
        .pix_data          (pix_data),
        .pix_valid         (pix_valid),
        .pix_ready         (pix_ready),
        .pix_last          (pix_last)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // SRAM controller model: requests are logged, returned in order after a
    // random latency of lat_min..lat_max cycles.
    initial begin
        avm_readdatavalid = 1'b0;
        avm_readdata      = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset_n) begin
                pend_addr.delete();
                pend_due.delete();
            end else if (avm_read) begin
                ctl_lat = int'($urandom_range(lat_max, lat_min));
                ctl_due = cyc + ctl_lat;
                if (pend_due.size() > 0 && ctl_due <= pend_due[$]) ctl_due = pend_due[$] + 1;
                pend_addr.push_back(avm_address);
                pend_due.push_back(ctl_due);
                rd_log.push_back(avm_address);
            end
            if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
                avm_readdatavalid = 1'b1;
                avm_readdata      = mem_f(pend_addr.pop_front());
                void'(pend_due.pop_front());
            end else if (inject_rdv) begin
                avm_readdatavalid = 1'b1;
                avm_readdata      = 16'hDEAD;
                inject_rdv        = 1'b0;
            end else begin
                avm_readdatavalid = 1'b0;
            end
        end
    end

    // LCD sink ready generator.
    initial begin
        pix_ready = 1'b0;
        forever begin
            @(negedge clk);
            pix_ready = (int'($urandom_range(99, 0)) < ready_pct);
        end
    end

    // Stream monitor: captures handshakes and frame_done, and checks that
    // reads in flight plus buffered pixels never exceed the FIFO depth.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (reset_n) begin
                if (pix_valid && pix_ready) begin
                    cap_data.push_back(pix_data);
                    cap_last.push_back(pix_last);
                end
                if (frame_done) begin
                    done_cnt++;
                    if (busy) busy_bad++;
                end
                if (rd_log.size() - cap_data.size() > DEPTH) credit_viol++;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got time limit reached, expected test completion");
        $fatal(1, "watchdog expired");
    end

    // Runs one frame: optional initial stall, optional start spamming while busy.
    task automatic do_frame(input int rpct, input int lmin, input int lmax,
                            input bit spam, input int stall, output bit tmo);
        int t0;
        rd_log.delete();
        cap_data.delete();
        cap_last.delete();
        done_cnt    = 0;
        busy_bad    = 0;
        credit_viol = 0;
        lat_min     = lmin;
        lat_max     = lmax;
        ready_pct   = (stall > 0) ? 0 : rpct;
        @(negedge clk);
        start = 1'b1;
        t0    = cyc;
        @(negedge clk);
        start = 1'b0;
        #1;
        first_read = avm_read;
        first_addr = avm_address;
        first_busy = busy;
        if (stall > 0) begin
            repeat (stall) @(negedge clk);
            #3;
            stall_reads = rd_log.size();
            stall_caps  = cap_data.size();
            stall_read  = avm_read;
            stall_valid = pix_valid;
            ready_pct   = rpct;
        end
        tmo = 1'b1;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            start = spam && busy && ($urandom_range(2, 0) == 0);
            #3;
            if (done_cnt > 0) begin
                tmo          = 1'b0;
                frame_cycles = cyc - t0;
                break;
            end
        end
        start = 1'b0;
        repeat (6) @(negedge clk);
        #3;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start   = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        asserts++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        asserts++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", frame_done); end
        asserts++; if (err_unexp !== 1'b0) begin failures++; $display("FAIL reset_err: got %b expected 0", err_unexp); end
        asserts++; if (avm_read !== 1'b0) begin failures++; $display("FAIL reset_read: got %b expected 0", avm_read); end
        asserts++; if (avm_address !== BASE) begin failures++; $display("FAIL reset_addr: got %h expected %h", avm_address, BASE); end
        asserts++; if (avm_byteenable !== 2'b11) begin failures++; $display("FAIL reset_be: got %b expected 11", avm_byteenable); end
        asserts++; if (pix_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", pix_valid); end
        asserts++; if (pix_last !== 1'b0) begin failures++; $display("FAIL reset_last: got %b expected 0", pix_last); end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // Basic frame, sink always ready, fixed latency 2.
    task automatic test_basic();
        bit tmo;
        do_frame(100, 2, 2, 1'b0, 0, tmo);
        asserts++; if (tmo !== 1'b0) begin failures++; $display("FAIL t1_timeout: got no frame_done expected frame_done"); end
        asserts++; if (first_read !== 1'b1 || first_addr !== BASE || first_busy !== 1'b1)
            begin failures++; $display("FAIL t1_first_read: got read=%b addr=%h busy=%b expected 1 %h 1", first_read, first_addr, first_busy, BASE); end
        asserts++; if (rd_log.size() != N) begin failures++; $display("FAIL t1_nreads: got %0d expected %0d", rd_log.size(), N); end
        else for (int k = 0; k < N; k++) begin
            asserts++;
            if (rd_log[k] !== BASE + 20'(k)) begin failures++; $display("FAIL t1_addr[%0d]: got %h expected %h", k, rd_log[k], BASE + 20'(k)); end
        end
        asserts++; if (cap_data.size() != N) begin failures++; $display("FAIL t1_npix: got %0d expected %0d", cap_data.size(), N); end
        else for (int k = 0; k < N; k++) begin
            asserts++;
            if (cap_data[k] !== mem_f(BASE + 20'(k)) || cap_last[k] !== (k == N - 1))
                begin failures++; $display("FAIL t1_pix[%0d]: got %h/%b expected %h/%b", k, cap_data[k], cap_last[k], mem_f(BASE + 20'(k)), (k == N - 1)); end
        end
        asserts++; if (done_cnt != 1) begin failures++; $display("FAIL t1_done_cnt: got %0d expected 1", done_cnt); end
        asserts++; if (busy_bad != 0) begin failures++; $display("FAIL t1_busy_at_done: got %0d expected 0", busy_bad); end
        asserts++; if (busy !== 1'b0) begin failures++; $display("FAIL t1_busy_after: got %b expected 0", busy); end
        asserts++; if (frame_cycles > N + 8) begin failures++; $display("FAIL t1_throughput: got %0d cycles expected <= %0d", frame_cycles, N + 8); end
    endtask

    // Sink stalled for 40 cycles: issue must stop at the FIFO depth.
    task automatic test_backpressure();
        bit tmo;
        do_frame(100, 3, 3, 1'b0, 40, tmo);
        asserts++; if (stall_reads != DEPTH) begin failures++; $display("FAIL t2_stall_reads: got %0d expected %0d", stall_reads, DEPTH); end
        asserts++; if (stall_read !== 1'b0) begin failures++; $display("FAIL t2_stall_avm_read: got %b expected 0", stall_read); end
        asserts++; if (stall_valid !== 1'b1 || stall_caps != 0) begin failures++; $display("FAIL t2_stall_valid: got valid=%b pops=%0d expected 1 0", stall_valid, stall_caps); end
        asserts++; if (tmo !== 1'b0) begin failures++; $display("FAIL t2_timeout: got no frame_done expected frame_done"); end
        asserts++; if (cap_data.size() != N) begin failures++; $display("FAIL t2_npix: got %0d expected %0d", cap_data.size(), N); end
        else for (int k = 0; k < N; k++) begin
            asserts++;
            if (cap_data[k] !== mem_f(BASE + 20'(k))) begin failures++; $display("FAIL t2_pix[%0d]: got %h expected %h", k, cap_data[k], mem_f(BASE + 20'(k))); end
        end
        asserts++; if (credit_viol != 0) begin failures++; $display("FAIL t2_credit: got %0d violations expected 0", credit_viol); end
    endtask

    // Random sink readiness and random in-order latency 1..4.
    task automatic test_random();
        bit tmo;
        for (int r = 0; r < 2; r++) begin
            do_frame(50, 1, 4, 1'b0, 0, tmo);
            asserts++; if (tmo !== 1'b0) begin failures++; $display("FAIL t3_timeout: got no frame_done expected frame_done"); end
            asserts++; if (cap_data.size() != N) begin failures++; $display("FAIL t3_npix: got %0d expected %0d", cap_data.size(), N); end
            else for (int k = 0; k < N; k++) begin
                asserts++;
                if (cap_data[k] !== mem_f(BASE + 20'(k)) || cap_last[k] !== (k == N - 1))
                    begin failures++; $display("FAIL t3_pix[%0d]: got %h/%b expected %h/%b", k, cap_data[k], cap_last[k], mem_f(BASE + 20'(k)), (k == N - 1)); end
            end
            asserts++; if (credit_viol != 0) begin failures++; $display("FAIL t3_credit: got %0d violations expected 0", credit_viol); end
            asserts++; if (done_cnt != 1) begin failures++; $display("FAIL t3_done_cnt: got %0d expected 1", done_cnt); end
        end
    endtask

    // start pulses while busy must be ignored; a later start refetches.
    task automatic test_start_ignored();
        bit tmo;
        do_frame(30, 1, 4, 1'b1, 0, tmo);
        asserts++; if (tmo !== 1'b0) begin failures++; $display("FAIL t4_timeout: got no frame_done expected frame_done"); end
        asserts++; if (done_cnt != 1) begin failures++; $display("FAIL t4_done_cnt: got %0d expected 1", done_cnt); end
        asserts++; if (rd_log.size() != N) begin failures++; $display("FAIL t4_nreads: got %0d expected %0d", rd_log.size(), N); end
        else for (int k = 0; k < N; k++) begin
            asserts++;
            if (rd_log[k] !== BASE + 20'(k)) begin failures++; $display("FAIL t4_addr[%0d]: got %h expected %h", k, rd_log[k], BASE + 20'(k)); end
        end
        asserts++; if (cap_data.size() != N) begin failures++; $display("FAIL t4_npix: got %0d expected %0d", cap_data.size(), N); end
        do_frame(100, 1, 1, 1'b0, 0, tmo);
        asserts++; if (tmo !== 1'b0 || rd_log.size() != N) begin failures++; $display("FAIL t4_refetch: got tmo=%b reads=%0d expected 0 %0d", tmo, rd_log.size(), N); end
        else begin
            asserts++; if (rd_log[0] !== BASE) begin failures++; $display("FAIL t4_refetch_base: got %h expected %h", rd_log[0], BASE); end
        end
        asserts++; if (cap_data.size() != N) begin failures++; $display("FAIL t4_refetch_npix: got %0d expected %0d", cap_data.size(), N); end
        else begin
            asserts++;
            if (cap_data[N - 1] !== mem_f(BASE + 20'(N - 1))) begin failures++; $display("FAIL t4_refetch_lastpix: got %h expected %h", cap_data[N - 1], mem_f(BASE + 20'(N - 1))); end
        end
    endtask

    // Unsolicited readdatavalid while idle sets a sticky error and is dropped.
    task automatic test_unexpected();
        asserts++; if (err_unexp !== 1'b0) begin failures++; $display("FAIL t5_err_before: got %b expected 0", err_unexp); end
        @(negedge clk);
        #1;
        inject_rdv = 1'b1;
        repeat (3) @(negedge clk);
        #3;
        asserts++; if (err_unexp !== 1'b1) begin failures++; $display("FAIL t5_err_set: got %b expected 1", err_unexp); end
        asserts++; if (pix_valid !== 1'b0) begin failures++; $display("FAIL t5_valid: got %b expected 0", pix_valid); end
        repeat (6) @(negedge clk);
        #3;
        asserts++; if (err_unexp !== 1'b1) begin failures++; $display("FAIL t5_err_sticky: got %b expected 1", err_unexp); end
        asserts++; if (pix_valid !== 1'b0 || busy !== 1'b0 || avm_read !== 1'b0)
            begin failures++; $display("FAIL t5_idle: got valid=%b busy=%b read=%b expected 0 0 0", pix_valid, busy, avm_read); end
    endtask

    // Asynchronous reset in the middle of a fetch, then a clean full frame.
    task automatic test_reset_mid();
        bit tmo;
        ready_pct = 100;
        lat_min   = 2;
        lat_max   = 2;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        #3;
        asserts++; if (busy !== 1'b1 || avm_read !== 1'b1) begin failures++; $display("FAIL t6_midframe: got busy=%b read=%b expected 1 1", busy, avm_read); end
        reset_n = 1'b0;
        #1;
        asserts++; if (busy !== 1'b0 || avm_read !== 1'b0 || frame_done !== 1'b0)
            begin failures++; $display("FAIL t6_async_ctl: got busy=%b read=%b done=%b expected 0 0 0", busy, avm_read, frame_done); end
        asserts++; if (avm_address !== BASE) begin failures++; $display("FAIL t6_async_addr: got %h expected %h", avm_address, BASE); end
        asserts++; if (pix_valid !== 1'b0 || pix_last !== 1'b0 || err_unexp !== 1'b0)
            begin failures++; $display("FAIL t6_async_out: got valid=%b last=%b err=%b expected 0 0 0", pix_valid, pix_last, err_unexp); end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        do_frame(70, 1, 3, 1'b0, 0, tmo);
        asserts++; if (tmo !== 1'b0) begin failures++; $display("FAIL t6_timeout: got no frame_done expected frame_done"); end
        asserts++; if (cap_data.size() != N) begin failures++; $display("FAIL t6_npix: got %0d expected %0d", cap_data.size(), N); end
        else for (int k = 0; k < N; k++) begin
            asserts++;
            if (cap_data[k] !== mem_f(BASE + 20'(k)) || cap_last[k] !== (k == N - 1))
                begin failures++; $display("FAIL t6_pix[%0d]: got %h/%b expected %h/%b", k, cap_data[k], cap_last[k], mem_f(BASE + 20'(k)), (k == N - 1)); end
        end
        asserts++; if (err_unexp !== 1'b0) begin failures++; $display("FAIL t6_err: got %b expected 0", err_unexp); end
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_random();
        test_start_ignored();
        test_unexpected();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule
`default_nettype wire
